// File: rtl/writeback_stage_pkg.sv
// Shared CPU datapath types used by the writeback stage and its bus interface.
package cpu_types_pkg;

  localparam int WORD_BITS = 32;
  localparam int REG_BITS  = 5;

  typedef logic [WORD_BITS-1:0] word_t;
  typedef logic [REG_BITS-1:0]  regbits_t;

  // Writeback sequencing: free, blocked on a data-memory load, or stopped by HALT.
  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_MEM = 2'd1,
    HALTED   = 2'd2
  } wb_state_t;

endpackage

// File: rtl/writeback_stage_if.sv
// Upstream handshake and instruction payload delivered into the writeback stage.
interface writeback_stage_if #(
  parameter int WORD_W     = 32,
  parameter int REG_ADDR_W = 5
);

  logic                  in_valid;
  logic                  in_ready;
  logic                  in_regwrite;
  logic                  in_memtoreg;
  logic                  in_link;
  logic                  in_halt;
  logic [REG_ADDR_W-1:0] in_wsel;
  logic [WORD_W-1:0]     in_alu_result;
  logic [WORD_W-1:0]     in_pc_plus4;

  // Upstream pipeline register side.
  modport master (
    output in_valid, in_regwrite, in_memtoreg, in_link, in_halt,
    output in_wsel, in_alu_result, in_pc_plus4,
    input  in_ready
  );

  // Writeback stage side.
  modport slave (
    input  in_valid, in_regwrite, in_memtoreg, in_link, in_halt,
    input  in_wsel, in_alu_result, in_pc_plus4,
    output in_ready
  );

endinterface

// File: rtl/writeback_stage.sv
// Writeback stage: retires one instruction at a time into the register file,
// blocks on outstanding loads, and keeps a one-entry slot so an instruction
// accepted on the load-return cycle retires right behind the load's write.
module writeback_stage
  import cpu_types_pkg::*;
#(
  parameter int WORD_W     = WORD_BITS,
  parameter int REG_ADDR_W = REG_BITS
) (
  input  logic                  clk,
  input  logic                  n_rst,
  writeback_stage_if.slave      bus,
  input  logic                  dhit,
  input  logic [WORD_W-1:0]     dmemload,
  output logic                  rf_wen,
  output logic [REG_ADDR_W-1:0] rf_wsel,
  output logic [WORD_W-1:0]     rf_wdat,
  output logic                  load_pending,
  output logic [REG_ADDR_W-1:0] pending_sel,
  output logic                  halt
);

  wb_state_t state;
  wb_state_t state_next;

  logic                  accept;
  logic                  new_load;
  logic                  new_write;
  logic [WORD_W-1:0]     new_dat;
  logic                  load_done;

  // Write presented to the register file on the next edge.
  logic                  wr_valid;
  logic [REG_ADDR_W-1:0] wr_sel;
  logic [WORD_W-1:0]     wr_dat;

  // Deferred write slot, used when a load and a new write retire back to back.
  logic                  def_valid;
  logic [REG_ADDR_W-1:0] def_sel;
  logic [WORD_W-1:0]     def_dat;
  logic                  def_valid_next;
  logic [REG_ADDR_W-1:0] def_sel_next;
  logic [WORD_W-1:0]     def_dat_next;

  assign accept    = bus.in_valid && bus.in_ready;
  assign new_load  = accept && !bus.in_halt && bus.in_regwrite && bus.in_memtoreg;
  assign new_write = accept && !bus.in_halt && bus.in_regwrite && !bus.in_memtoreg;
  assign new_dat   = bus.in_link ? bus.in_pc_plus4 : bus.in_alu_result;
  assign load_done = (state == WAIT_MEM) && dhit;

  // State register.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state decode: an acceptance from WAIT_MEM follows the IDLE rules.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (accept) begin
          if (bus.in_halt)   state_next = HALTED;
          else if (new_load) state_next = WAIT_MEM;
        end
      end
      WAIT_MEM: begin
        if (dhit) begin
          if (accept && bus.in_halt) state_next = HALTED;
          else if (new_load)         state_next = WAIT_MEM;
          else                       state_next = IDLE;
        end
      end
      HALTED:  state_next = HALTED;
      default: state_next = IDLE;
    endcase
  end

  // State-decoded outputs: ready and the pending-load flag for the hazard unit.
  always_comb begin
    bus.in_ready = 1'b0;
    load_pending = 1'b0;
    case (state)
      IDLE:     bus.in_ready = 1'b1;
      WAIT_MEM: begin
        bus.in_ready = dhit;
        load_pending = 1'b1;
      end
      default: ;
    endcase
  end

  // Choose the write for the next edge; older work (load, then deferred) goes first.
  always_comb begin
    wr_valid       = 1'b0;
    wr_sel         = '0;
    wr_dat         = '0;
    def_valid_next = 1'b0;
    def_sel_next   = def_sel;
    def_dat_next   = def_dat;
    if (load_done) begin
      wr_valid       = 1'b1;
      wr_sel         = pending_sel;
      wr_dat         = dmemload;
      def_valid_next = new_write;
      def_sel_next   = bus.in_wsel;
      def_dat_next   = new_dat;
    end else if (def_valid) begin
      wr_valid       = 1'b1;
      wr_sel         = def_sel;
      wr_dat         = def_dat;
      def_valid_next = new_write;
      def_sel_next   = bus.in_wsel;
      def_dat_next   = new_dat;
    end else if (new_write) begin
      wr_valid = 1'b1;
      wr_sel   = bus.in_wsel;
      wr_dat   = new_dat;
    end
  end

  // Registered register-file port, deferred slot, pending destination and sticky halt.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      rf_wen      <= 1'b0;
      rf_wsel     <= '0;
      rf_wdat     <= '0;
      def_valid   <= 1'b0;
      def_sel     <= '0;
      def_dat     <= '0;
      pending_sel <= '0;
      halt        <= 1'b0;
    end else begin
      // r0 is hardwired to zero, so a write aimed at it never asserts the enable.
      rf_wen <= wr_valid && (wr_sel != '0);
      if (wr_valid) begin
        rf_wsel <= wr_sel;
        rf_wdat <= wr_dat;
      end
      def_valid <= def_valid_next;
      def_sel   <= def_sel_next;
      def_dat   <= def_dat_next;
      if (new_load) begin
        pending_sel <= bus.in_wsel;
      end
      if (accept && bus.in_halt) begin
        halt <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_writeback_stage.sv
// Bench for writeback_stage: directed scenarios plus randomized traffic, with an
// in-order retirement scoreboard and per-cycle handshake/status checks.
module tb_writeback_stage;

  logic        clk;
  logic        n_rst;
  logic        dhit;
  logic [31:0] dmemload;
  logic        rf_wen;
  logic [4:0]  rf_wsel;
  logic [31:0] rf_wdat;
  logic        load_pending;
  logic [4:0]  pending_sel;
  logic        halt;

  writeback_stage_if #(.WORD_W(32), .REG_ADDR_W(5)) bus ();

  writeback_stage #(.WORD_W(32), .REG_ADDR_W(5)) dut (
    .clk          (clk),
    .n_rst        (n_rst),
    .bus          (bus.slave),
    .dhit         (dhit),
    .dmemload     (dmemload),
    .rf_wen       (rf_wen),
    .rf_wsel      (rf_wsel),
    .rf_wdat      (rf_wdat),
    .load_pending (load_pending),
    .pending_sel  (pending_sel),
    .halt         (halt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  sel;
    logic [31:0] dat;
  } wr_t;

  wr_t exp_q[$];
  int  errors = 0;
  int  checks = 0;

  // Reference model: retirement is strictly in program order; a load's value
  // becomes known when memory answers.
  bit         m_wait;
  bit         m_halted;
  logic [4:0] m_psel;

  // Expected status for the current cycle (before the coming clock edge).
  bit         snap_valid;
  bit         exp_ready;
  bit         exp_pend;
  bit         exp_halt;
  logic [4:0] exp_psel;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push_write(input logic [4:0] sel, input logic [31:0] dat);
    wr_t e;
    if (sel != 5'd0) begin
      e.sel = sel;
      e.dat = dat;
      exp_q.push_back(e);
    end
  endtask

  // Present one cycle of stimulus and advance the model across the coming edge.
  task automatic drive(input bit v, input bit rw, input bit mr, input bit lk, input bit hl,
                       input logic [4:0] ws, input logic [31:0] alu, input logic [31:0] pc4,
                       input bit dh, input logic [31:0] dm);
    bit acc;
    @(posedge clk);
    #1;
    bus.in_valid      = v;
    bus.in_regwrite   = rw;
    bus.in_memtoreg   = mr;
    bus.in_link       = lk;
    bus.in_halt       = hl;
    bus.in_wsel       = ws;
    bus.in_alu_result = alu;
    bus.in_pc_plus4   = pc4;
    dhit              = dh;
    dmemload          = dm;
    exp_ready  = !m_halted && (!m_wait || dh);
    exp_pend   = m_wait;
    exp_halt   = m_halted;
    exp_psel   = m_psel;
    snap_valid = 1'b1;
    acc = v && exp_ready;
    if (m_wait && dh) begin
      push_write(m_psel, dm);
      m_wait = 1'b0;
    end
    if (acc) begin
      if (hl) begin
        m_halted = 1'b1;
      end else if (rw && mr) begin
        m_wait = 1'b1;
        m_psel = ws;
      end else if (rw) begin
        push_write(ws, lk ? pc4 : alu);
      end
    end
  endtask

  task automatic idle(input bit dh, input logic [31:0] dm);
    drive(0, 0, 0, 0, 0, 5'd0, 32'd0, 32'd0, dh, dm);
  endtask

  // Directed timing check on the register-file port, one cycle after a given edge.
  task automatic expect_wr(input string name, input bit wen, input logic [4:0] sel,
                           input logic [31:0] dat);
    @(negedge clk);
    chk({name, "_wen"}, {31'd0, rf_wen}, {31'd0, wen});
    if (wen) begin
      chk({name, "_wsel"}, {27'd0, rf_wsel}, {27'd0, sel});
      chk({name, "_wdat"}, rf_wdat, dat);
    end
  endtask

  task automatic do_reset();
    @(posedge clk);
    #2;
    n_rst             = 1'b0;
    snap_valid        = 1'b0;
    bus.in_valid      = 1'b0;
    bus.in_regwrite   = 1'b0;
    bus.in_memtoreg   = 1'b0;
    bus.in_link       = 1'b0;
    bus.in_halt       = 1'b0;
    bus.in_wsel       = 5'd0;
    bus.in_alu_result = 32'd0;
    bus.in_pc_plus4   = 32'd0;
    dhit              = 1'b0;
    dmemload          = 32'd0;
    m_wait   = 1'b0;
    m_halted = 1'b0;
    m_psel   = 5'd0;
    exp_q.delete();
    #1;
    chk("rst_rf_wen", {31'd0, rf_wen}, 32'd0);
    chk("rst_rf_wsel", {27'd0, rf_wsel}, 32'd0);
    chk("rst_rf_wdat", rf_wdat, 32'd0);
    chk("rst_pending_sel", {27'd0, pending_sel}, 32'd0);
    chk("rst_halt", {31'd0, halt}, 32'd0);
    chk("rst_load_pending", {31'd0, load_pending}, 32'd0);
    chk("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
    @(posedge clk);
    #2;
    n_rst = 1'b1;
  endtask

  // Monitor: per-cycle status checks and in-order scoreboard of register writes.
  always @(negedge clk) begin
    wr_t e;
    if (n_rst) begin
      if (snap_valid) begin
        chk("in_ready", {31'd0, bus.in_ready}, {31'd0, exp_ready});
        chk("load_pending", {31'd0, load_pending}, {31'd0, exp_pend});
        chk("halt", {31'd0, halt}, {31'd0, exp_halt});
        chk("pending_sel", {27'd0, pending_sel}, {27'd0, exp_psel});
      end
      if (rf_wen) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_write: got r%0d=%h required no write at %0t",
                   rf_wsel, rf_wdat, $time);
        end else begin
          e = exp_q.pop_front();
          chk("sb_wsel", {27'd0, rf_wsel}, {27'd0, e.sel});
          chk("sb_wdat", rf_wdat, e.dat);
          $display("retire r%0d <= %h at %0t", rf_wsel, rf_wdat, $time);
        end
      end
    end
  end

  initial begin
    n_rst      = 1'b0;
    snap_valid = 1'b0;
    dhit       = 1'b0;
    dmemload   = 32'd0;
    do_reset();

    // ALU write, one-cycle latency.
    drive(1, 1, 0, 0, 0, 5'd5, 32'h0000_1234, 32'd0, 0, 32'd0);
    idle(0, 32'd0);
    expect_wr("alu", 1, 5'd5, 32'h0000_1234);

    // Load to r8, memory answers three cycles after acceptance.
    drive(1, 1, 1, 0, 0, 5'd8, 32'h1111_1111, 32'd0, 0, 32'd0);
    idle(0, 32'd0);
    expect_wr("load_wait1", 0, 5'd0, 32'd0);
    idle(0, 32'd0);
    expect_wr("load_wait2", 0, 5'd0, 32'd0);
    idle(1, 32'hDEAD_BEEF);
    idle(0, 32'd0);
    expect_wr("load", 1, 5'd8, 32'hDEAD_BEEF);

    // Write to r0 is suppressed.
    drive(1, 1, 0, 0, 0, 5'd0, 32'hFFFF_FFFF, 32'd0, 0, 32'd0);
    idle(0, 32'd0);
    expect_wr("r0", 0, 5'd0, 32'd0);

    // JAL writes the link address.
    drive(1, 1, 0, 1, 0, 5'd31, 32'h5555_5555, 32'h0000_0040, 0, 32'd0);
    idle(0, 32'd0);
    expect_wr("jal", 1, 5'd31, 32'h0000_0040);

    // Load return and new ALU write in the same cycle retire back to back.
    drive(1, 1, 1, 0, 0, 5'd9, 32'd0, 32'd0, 0, 32'd0);
    idle(0, 32'd0);
    drive(1, 1, 0, 0, 0, 5'd10, 32'h0000_0007, 32'd0, 1, 32'hCAFE_0009);
    idle(0, 32'd0);
    expect_wr("b2b_load", 1, 5'd9, 32'hCAFE_0009);
    idle(0, 32'd0);
    expect_wr("b2b_alu", 1, 5'd10, 32'h0000_0007);

    // HALT with regwrite set: no write, sticky, later input ignored.
    drive(1, 1, 0, 0, 1, 5'd3, 32'h0000_0005, 32'd0, 0, 32'd0);
    drive(1, 1, 0, 0, 0, 5'd4, 32'h0000_0009, 32'd0, 1, 32'h0BAD_0BAD);
    idle(0, 32'd0);
    expect_wr("halted", 0, 5'd0, 32'd0);
    chk("halt_sticky", {31'd0, halt}, 32'd1);
    do_reset();

    // Reset in the middle of a load drops it; a later dhit writes nothing.
    drive(1, 1, 1, 0, 0, 5'd7, 32'd0, 32'd0, 0, 32'd0);
    idle(0, 32'd0);
    do_reset();
    idle(1, 32'hAAAA_AAAA);
    idle(1, 32'hBBBB_BBBB);
    idle(0, 32'd0);
    expect_wr("post_reset", 0, 5'd0, 32'd0);

    // Randomized traffic in several episodes, each ended by a drain and reset.
    for (int ep = 0; ep < 6; ep++) begin
      for (int c = 0; c < 250; c++) begin
        drive($urandom_range(0, 9) < 7,
              $urandom_range(0, 9) < 8,
              $urandom_range(0, 9) < 3,
              $urandom_range(0, 9) < 2,
              $urandom_range(0, 399) == 0,
              5'($urandom_range(0, 31)),
              $urandom, $urandom,
              $urandom_range(0, 9) < 4,
              $urandom);
      end
      for (int d = 0; d < 3; d++) begin
        idle(0, 32'd0);
      end
      @(negedge clk);
      chk("drain_empty", exp_q.size(), 32'd0);
      do_reset();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
